// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared opcodes, JEDEC ID bytes and FSM state type for the SPI flash master
package spi_flash_pkg;

    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_WRDIS    = 8'h04;
    localparam logic [7:0] OP_RDSR     = 8'h05;
    localparam logic [7:0] OP_WREN     = 8'h06;
    localparam logic [7:0] OP_RDID_ALT = 8'h9E;
    localparam logic [7:0] OP_RDID     = 8'h9F;
    localparam logic [7:0] OP_EN4B     = 8'hB7;
    localparam logic [7:0] OP_EX4B     = 8'hE9;
    localparam logic [7:0] OP_LOG      = 8'hF2;

    localparam logic [7:0] JEDEC_MFR   = 8'h20;
    localparam logic [7:0] JEDEC_TYPE  = 8'hBA;
    localparam logic [7:0] JEDEC_CAP   = 8'h19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRESET,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

endpackage

// File: rtl/spi_flash_master_clk_gen.sv
// rtl/spi_flash_master_clk_gen.sv - half-period counter producing spi_clk and its rise/fall enables
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o,
    output logic sclk_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic        last;

    assign last   = (cnt_q == 16'(CLK_DIV - 1));
    assign rise_o = en_i && !phase_q && last;
    assign fall_o = en_i && phase_q && last;
    assign sclk_o = phase_q;

    // Disabling the generator parks it at the start of a low phase.
    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en_i) begin
            if (last) begin
                cnt_d   = '0;
                phase_d = !phase_q;
            end else begin
                cnt_d   = cnt_q + 16'd1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_flash_master.sv
// rtl/spi_flash_master.sv - SPI mode-0 initiator issuing flash command frames and target reset pulses
module spi_flash_master
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 4,
    parameter int RST_CYCLES = 16,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_opcode,
    input  logic             cmd_addr_en,
    input  logic             cmd_addr_4byte,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_rd_len,
    input  logic             tgt_reset_req,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             done,
    output logic             busy,
    output logic             spi_clk,
    output logic             spi_csel,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_reset
);

    localparam int BITS_MAX = 40 + 8 * ((2 ** LEN_W) - 1);
    localparam int BIT_W    = $clog2(BITS_MAX + 1);
    localparam int DAT_W    = LEN_W + 3;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]   bits_q, bits_d;
    logic [DAT_W-1:0]   dbits_q, dbits_d;
    logic [38:0]        hdr_q, hdr_d;
    logic [6:0]         sh_q, sh_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               mosi_q, mosi_d;
    logic               rx_valid_q, rx_valid_d;
    logic               done_q, done_d;
    logic               rise, fall, sclk;
    logic               in_data, next_in_data;
    logic [BIT_W-1:0]   bits_m1;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (state_q == ST_SHIFT),
        .rise_o  (rise),
        .fall_o  (fall),
        .sclk_o  (sclk)
    );

    // bits_q counts remaining bits; the last 8*rd_len of them are data bits.
    assign bits_m1      = bits_q - 1'b1;
    assign in_data      = (bits_q <= BIT_W'(dbits_q));
    assign next_in_data = (bits_m1 <= BIT_W'(dbits_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        dbits_d    = dbits_q;
        hdr_d      = hdr_q;
        sh_d       = sh_q;
        rx_data_d  = rx_data_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tgt_reset_req) begin
                    state_d = ST_TRESET;
                    cnt_d   = '0;
                end else if (cmd_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    bits_d  = BIT_W'({cmd_rd_len, 3'b000})
                            + BIT_W'(cmd_addr_en ? (cmd_addr_4byte ? 40 : 32) : 8);
                    dbits_d = {cmd_rd_len, 3'b000};
                    hdr_d   = cmd_addr_4byte ? {cmd_opcode[6:0], cmd_addr}
                                             : {cmd_opcode[6:0], cmd_addr[23:0], 8'h00};
                    mosi_d  = cmd_opcode[7];
                end
            end
            ST_TRESET: begin
                if (cnt_q == 16'(RST_CYCLES - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (rise && in_data) begin
                    sh_d = {sh_q[5:0], spi_miso};
                    if (bits_q[2:0] == 3'b001) begin
                        rx_data_d  = {sh_q, spi_miso};
                        rx_valid_d = 1'b1;
                    end
                end
                if (fall) begin
                    bits_d = bits_m1;
                    hdr_d  = {hdr_q[37:0], 1'b0};
                    mosi_d = next_in_data ? 1'b0 : hdr_q[38];
                    if (bits_q == BIT_W'(1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'(CS_GAP - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bits_q     <= '0;
            dbits_q    <= '0;
            hdr_q      <= '0;
            sh_q       <= '0;
            rx_data_q  <= '0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            dbits_q    <= dbits_d;
            hdr_q      <= hdr_d;
            sh_q       <= sh_d;
            rx_data_q  <= rx_data_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
        end
    end

    // Chip select decodes straight from state so reset raises it without waiting for a clock.
    assign spi_csel  = !(state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    assign spi_reset = (state_q == ST_TRESET);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign spi_clk   = sclk;
    assign spi_mosi  = mosi_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_spi_flash_master.sv
// tb/tb_spi_flash_master.sv - directed bench for spi_flash_master with a small SPI flash target model
module tb_spi_flash_master;
    import spi_flash_pkg::*;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_addr_en, cmd_addr_4byte, tgt_reset_req;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_rd_len;
    logic        cmd_ready, rx_valid, done, busy, spi_clk, spi_csel, spi_mosi, spi_reset;
    logic [7:0]  rx_data;
    logic        f_miso = 1'b0;

    logic        rst1, cmd_valid1;
    logic        cmd_ready1, rx_valid1, done1, busy1, spi_clk1, spi_csel1, spi_mosi1, spi_reset1;
    logic [7:0]  rx_data1;

    int n_checks = 0;
    int n_fail   = 0;

    spi_flash_master u_dut (
        .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_addr_en(cmd_addr_en), .cmd_addr_4byte(cmd_addr_4byte),
        .cmd_addr(cmd_addr), .cmd_rd_len(cmd_rd_len), .tgt_reset_req(tgt_reset_req),
        .rx_valid(rx_valid), .rx_data(rx_data), .done(done), .busy(busy),
        .spi_clk(spi_clk), .spi_csel(spi_csel), .spi_mosi(spi_mosi), .spi_miso(f_miso),
        .spi_reset(spi_reset)
    );

    spi_flash_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(rst1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_opcode(OP_READ), .cmd_addr_en(1'b1), .cmd_addr_4byte(1'b0),
        .cmd_addr(32'h0000_0000), .cmd_rd_len(16'd4), .tgt_reset_req(1'b0),
        .rx_valid(rx_valid1), .rx_data(rx_data1), .done(done1), .busy(busy1),
        .spi_clk(spi_clk1), .spi_csel(spi_csel1), .spi_mosi(spi_mosi1), .spi_miso(1'b0),
        .spi_reset(spi_reset1)
    );

    always #5 clk = ~clk;

    // Flash target model: status WEL bit, 4-byte mode, JEDEC ID, synthetic memory.
    int          rises = 0, last_rises = 0, frames = 0;
    logic [63:0] mosi_sr = '0;
    logic [7:0]  f_op = '0;
    logic [31:0] f_addr = '0;
    logic        f_wel = 1'b0, f_4b = 1'b0;

    function automatic int hdr_len(input logic [7:0] op, input logic four);
        return (op == OP_READ) ? (four ? 40 : 32) : 8;
    endfunction

    function automatic logic [7:0] resp_byte(input logic [7:0] op, input logic [31:0] a,
                                             input logic wel, input int k);
        logic [31:0] ak;
        ak = a + 32'(k);
        case (op)
            OP_RDSR:           return {6'b0, wel, 1'b0};
            OP_RDID, OP_RDID_ALT:
                return (k == 0) ? JEDEC_MFR : (k == 1) ? JEDEC_TYPE : (k == 2) ? JEDEC_CAP : 8'h00;
            OP_READ:           return ak[7:0] ^ ak[15:8] ^ 8'h5A;
            default:           return 8'h00;
        endcase
    endfunction

    function automatic logic resp_bit(input logic [7:0] op, input logic [31:0] a, input logic wel,
                                      input logic four, input int n);
        int d;
        logic [7:0] b;
        d = n - hdr_len(op, four);
        if (n < 8 || d < 0) return 1'b0;
        b = resp_byte(op, a, wel, d / 8);
        return b[7 - (d % 8)];
    endfunction

    always @(posedge spi_clk or posedge spi_csel or posedge spi_reset) begin
        if (spi_reset) begin
            f_wel <= 1'b0;
            f_4b  <= 1'b0;
            rises <= 0;
        end else if (spi_csel) begin
            if (rises == 8) begin
                case (f_op)
                    OP_WREN:  f_wel <= 1'b1;
                    OP_WRDIS: f_wel <= 1'b0;
                    OP_EN4B:  f_4b  <= 1'b1;
                    OP_EX4B:  f_4b  <= 1'b0;
                    default:  ;
                endcase
            end
            last_rises <= rises;
            frames     <= frames + 1;
            rises      <= 0;
        end else begin
            mosi_sr <= {mosi_sr[62:0], spi_mosi};
            rises   <= rises + 1;
            if (rises == 7) f_op <= {mosi_sr[6:0], spi_mosi};
            if (f_op == OP_READ && rises == hdr_len(f_op, f_4b) - 1)
                f_addr <= f_4b ? {mosi_sr[30:0], spi_mosi} : {8'h00, mosi_sr[22:0], spi_mosi};
        end
    end

    always @(negedge spi_clk) begin
        if (!spi_csel) f_miso <= resp_bit(f_op, f_addr, f_wel, f_4b, rises);
    end

    logic [7:0] rxq[$];
    int  done_cnt = 0, rst_hi = 0, rst_csel_bad = 0, done1_cnt = 0, rxv1_cnt = 0, rises1 = 0;
    time last_rise1 = 0, prev_rise1 = 0;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (done) done_cnt <= done_cnt + 1;
        if (spi_reset) rst_hi <= rst_hi + 1;
        if (spi_reset && !spi_csel) rst_csel_bad <= rst_csel_bad + 1;
        if (done1) done1_cnt <= done1_cnt + 1;
        if (rx_valid1) rxv1_cnt <= rxv1_cnt + 1;
    end

    always @(posedge spi_clk1) begin
        rises1     <= rises1 + 1;
        prev_rise1 <= last_rise1;
        last_rise1 <= $time;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rx(input string tag, input int idx, input logic [7:0] exp);
        logic [8:0] got;
        got = (idx < rxq.size()) ? {1'b0, rxq[idx]} : 9'h100;
        check(tag, 64'(got), 64'(exp));
    endtask

    task automatic wait_done_idle(input string tag, input int d0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " done seen"}, 64'(ok), 64'd1);
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check({tag, " done count"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] op, input logic aen, input logic a4,
                           input logic [31:0] addr, input logic [15:0] len);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        cmd_opcode = op; cmd_addr_en = aen; cmd_addr_4byte = a4; cmd_addr = addr; cmd_rd_len = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, " busy"}, 64'({busy, cmd_ready}), 64'(2'b10));
        wait_done_idle(tag, d0);
    endtask

    task automatic do_treset(input string tag, input bit with_cmd);
        int d0, r0, b0, fr0;
        d0 = done_cnt; r0 = rst_hi; b0 = rst_csel_bad; fr0 = frames;
        @(negedge clk);
        tgt_reset_req = 1'b1;
        if (with_cmd) begin
            cmd_opcode = OP_RDSR; cmd_addr_en = 1'b0; cmd_rd_len = 16'd1; cmd_valid = 1'b1;
        end
        @(negedge clk);
        tgt_reset_req = 1'b0;
        cmd_valid     = 1'b0;
        check({tag, " spi_reset"}, 64'(spi_reset), 64'd1);
        wait_done_idle(tag, d0);
        check({tag, " reset cycles"}, 64'(rst_hi - r0), 64'd16);
        check({tag, " csel high"}, 64'(rst_csel_bad - b0), 64'd0);
        check({tag, " no frame"}, 64'(frames - fr0), 64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rx0;
        rst = 1'b1; rst1 = 1'b1; cmd_valid = 1'b0; cmd_valid1 = 1'b0; tgt_reset_req = 1'b0;
        cmd_opcode = '0; cmd_addr_en = 1'b0; cmd_addr_4byte = 1'b0; cmd_addr = '0; cmd_rd_len = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        check("rst cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst pins", 64'({spi_clk, spi_csel, spi_mosi, spi_reset}), 64'(4'b0100));
        check("rst rx", 64'({rx_valid, rx_data, done}), 64'd0);

        do_treset("treset", 1'b0);

        rx0 = rxq.size();
        run_cmd("rdsr0", OP_RDSR, 1'b0, 1'b0, 32'h0, 16'd1);
        check("rdsr0 rises", 64'(last_rises), 64'd16);
        check("rdsr0 rx count", 64'(rxq.size() - rx0), 64'd1);
        check_rx("rdsr0 byte", rx0, 8'h00);

        rx0 = rxq.size();
        run_cmd("wren", OP_WREN, 1'b0, 1'b0, 32'h0, 16'd0);
        check("wren rises", 64'(last_rises), 64'd8);
        check("wren rx count", 64'(rxq.size() - rx0), 64'd0);
        run_cmd("rdsr1", OP_RDSR, 1'b0, 1'b0, 32'h0, 16'd1);
        check_rx("rdsr1 byte", rx0, 8'h02);

        rx0 = rxq.size();
        run_cmd("rdid", OP_RDID, 1'b0, 1'b0, 32'h0, 16'd4);
        check("rdid rises", 64'(last_rises), 64'd40);
        check("rdid rx count", 64'(rxq.size() - rx0), 64'd4);
        check_rx("rdid b0", rx0, 8'h20);
        check_rx("rdid b1", rx0 + 1, 8'hBA);
        check_rx("rdid b2", rx0 + 2, 8'h19);
        check_rx("rdid b3", rx0 + 3, 8'h00);

        run_cmd("wren2", OP_WREN, 1'b0, 1'b0, 32'h0, 16'd0);
        run_cmd("en4b", OP_EN4B, 1'b0, 1'b0, 32'h0, 16'd0);
        rx0 = rxq.size();
        run_cmd("read4", OP_READ, 1'b1, 1'b1, 32'h0000_1234, 16'd2);
        check("read4 rises", 64'(last_rises), 64'd56);
        check("read4 header", 64'(mosi_sr[55:16]), 64'h03_0000_1234);
        check("read4 data mosi", 64'(mosi_sr[15:0]), 64'd0);
        check("read4 rx count", 64'(rxq.size() - rx0), 64'd2);
        check_rx("read4 b0", rx0, 8'h7C);
        check_rx("read4 b1", rx0 + 1, 8'h7D);

        do_treset("treset+cmd", 1'b1);
        rx0 = rxq.size();
        run_cmd("read3", OP_READ, 1'b1, 1'b0, 32'h0000_0100, 16'd1);
        check("read3 rises", 64'(last_rises), 64'd40);
        check_rx("read3 b0", rx0, 8'h5B);

        begin : abort_test
            bit ok;
            @(negedge clk);
            cmd_valid1 = 1'b1;
            @(negedge clk);
            cmd_valid1 = 1'b0;
            check("div1 busy", 64'(busy1), 64'd1);
            ok = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (rises1 >= 20) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("div1 reach bit 20", 64'(ok), 64'd1);
            check("div1 sclk period", 64'(last_rise1 - prev_rise1), 64'd20);
            check("div1 csel low mid-frame", 64'(spi_csel1), 64'd0);
            rst1 = 1'b1;
            #1;
            check("div1 csel async", 64'(spi_csel1), 64'd1);
            check("div1 sclk reset", 64'(spi_clk1), 64'd0);
            repeat (3) @(negedge clk);
            rst1 = 1'b0;
            repeat (3) @(negedge clk);
            check("div1 ready after", 64'({cmd_ready1, busy1}), 64'(2'b10));
            check("div1 no done", 64'(done1_cnt), 64'd0);
            check("div1 no rx", 64'(rxv1_cnt), 64'd0);
            check("div1 idle pins", 64'({spi_mosi1, spi_reset1, rx_data1}), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
